// File: rtl/shift_unit.sv
// -----------------------------------------------------------------------------
// shift_unit
//   Iterative shifter for the RV32I shift instructions (SLL/SRL/SRA and their
//   immediate forms). An accepted request is shifted STEP bits per cycle. The
//   final value and destination register are then presented together with a
//   one-cycle done pulse for regfile writeback. This trades latency for area
//   compared with a combinational barrel shifter.
//
// Parameters
//   XLEN     operand/result width
//   SHAMT_W  shift-amount width (log2 XLEN)
//   STEP     bits shifted per SHIFT cycle, 1..XLEN/2
//
// Ports
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   start_i   issue request, accepted only while ready_o=1
//   op_i      00=SLL 01=SRL 11=SRA 10=reserved (passes a_i through)
//   a_i       operand (rs1)
//   shamt_i   shift amount
//   rd_i      destination register index
//   flush_i   synchronous abort of the in-flight operation
//   ready_o   unit idle, can accept start_i
//   busy_o    operation in flight
//   done_o    result_o/rd_o valid this cycle, one-cycle pulse
//   result_o  shifted value, held until the next completed operation
//   rd_o      destination register for result_o
// -----------------------------------------------------------------------------
module shift_unit #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_i,
    input  logic [1:0]         op_i,
    input  logic [XLEN-1:0]    a_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [4:0]         rd_i,
    input  logic               flush_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [XLEN-1:0]    result_o,
    output logic [4:0]         rd_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRA  = 2'b11;
    localparam logic [1:0] OP_RSVD = 2'b10;

    localparam logic [SHAMT_W-1:0] STEP_N = SHAMT_W'(STEP);

    logic [1:0]         state_q;
    logic [XLEN-1:0]    work_q;       // partially shifted operand
    logic [1:0]         op_q;
    logic               sign_q;       // captured a_i MSB, SRA fill bit
    logic [SHAMT_W-1:0] remaining_q;
    logic [4:0]         rd_pend_q;    // rd of the in-flight op
    logic [XLEN-1:0]    result_q;
    logic [4:0]         rd_q;

    logic [SHAMT_W-1:0] step_n;
    logic [XLEN-1:0]    fill_mask;
    logic [XLEN-1:0]    shifted;

    // One shift step: the last step may be shorter than STEP.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        step_n    = (remaining_q < STEP_N) ? remaining_q : STEP_N;
        fill_mask = ~({XLEN{1'b1}} >> step_n);
        shifted   = work_q >> step_n;
        case (op_q)
            OP_SLL:  shifted = work_q << step_n;
            OP_SRA:  shifted = (work_q >> step_n) | (sign_q ? fill_mask : '0);
            default: shifted = work_q >> step_n;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            op_q        <= '0;
            sign_q      <= 1'b0;
            remaining_q <= '0;
            rd_pend_q   <= '0;
            result_q    <= '0;
            rd_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A flush in the same cycle drops the start.
                    if (start_i && !flush_i) begin
                        work_q    <= a_i;
                        op_q      <= op_i;
                        sign_q    <= a_i[XLEN-1];
                        rd_pend_q <= rd_i;
                        if (shamt_i == '0 || op_i == OP_RSVD) begin
                            // Nothing to shift: publish the operand directly.
                            remaining_q <= '0;
                            result_q    <= a_i;
                            rd_q        <= rd_i;
                            state_q     <= S_DONE;
                        end else begin
                            remaining_q <= shamt_i;
                            state_q     <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (flush_i) begin
                        // Abort: visible result/rd keep the previous op's values.
                        remaining_q <= '0;
                        state_q     <= S_IDLE;
                    end else begin
                        work_q      <= shifted;
                        remaining_q <= remaining_q - step_n;
                        if (remaining_q == step_n) begin
                            result_q <= shifted;
                            rd_q     <= rd_pend_q;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign busy_o   = !ready_o;
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;
    assign rd_o     = rd_q;

endmodule

// File: tb/tb_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_unit
//   Directed bench for shift_unit. Two instances share all inputs: one with
//   STEP=1 and one with STEP=4. Latency, result, rd, pulse width, flush, busy
//   retry and async reset are checked against hand-computed values.
// -----------------------------------------------------------------------------
module tb_shift_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [4:0]  shamt_i;
    logic [4:0]  rd_i;
    logic        flush_i;

    logic        ready1, busy1, done1;
    logic [31:0] result1;
    logic [4:0]  rd1;
    logic        ready4, busy4, done4;
    logic [31:0] result4;
    logic [4:0]  rd4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_unit #(.XLEN(32), .SHAMT_W(5), .STEP(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .shamt_i(shamt_i), .rd_i(rd_i), .flush_i(flush_i),
        .ready_o(ready1), .busy_o(busy1), .done_o(done1),
        .result_o(result1), .rd_o(rd1)
    );

    shift_unit #(.XLEN(32), .SHAMT_W(5), .STEP(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .op_i(op_i),
        .a_i(a_i), .shamt_i(shamt_i), .rd_i(rd_i), .flush_i(flush_i),
        .ready_o(ready4), .busy_o(busy4), .done_o(done4),
        .result_o(result4), .rd_o(rd4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op to both instances and watch 40 cycles. exp_c1/exp_c4 are
    // the cycles (after the start cycle) in which done_o must be seen.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [4:0] sh, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_c1, input int exp_c4);
        int c1 = 0, c4 = 0, p1 = 0, p4 = 0;
        logic [31:0] r1 = '0, r4 = '0;
        logic [4:0]  d1 = '0, d4 = '0;
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; shamt_i = sh; rd_i = rd;
        @(negedge clk);
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done1) begin
                p1++;
                if (c1 == 0) begin c1 = cyc; r1 = result1; d1 = rd1; end
            end
            if (done4) begin
                p4++;
                if (c4 == 0) begin c4 = cyc; r4 = result4; d4 = rd4; end
            end
            @(negedge clk);
        end
        check({tag, "/lat_step1"}, 32'(c1), 32'(exp_c1));
        check({tag, "/lat_step4"}, 32'(c4), 32'(exp_c4));
        check({tag, "/res_step1"}, r1, exp);
        check({tag, "/res_step4"}, r4, exp);
        check({tag, "/rd_step1"}, {27'd0, d1}, {27'd0, rd});
        check({tag, "/rd_step4"}, {27'd0, d4}, {27'd0, rd});
        check({tag, "/pulses_step1"}, 32'(p1), 32'd1);
        check({tag, "/pulses_step4"}, 32'(p4), 32'd1);
        check({tag, "/held_step1"}, result1, exp);
        check({tag, "/ready_after"}, {31'd0, ready1 & ready4}, 32'd1);
    endtask

    initial begin
        int dones;
        reset_n = 1'b0; start_i = 1'b0; op_i = '0; a_i = '0;
        shamt_i = '0; rd_i = '0; flush_i = 1'b0;

        // Reset state
        #7;
        check("rst/result", result1, 32'h0);
        check("rst/rd", {27'd0, rd1}, 32'h0);
        check("rst/ready", {31'd0, ready1}, 32'd1);
        check("rst/busy", {31'd0, busy1}, 32'd0);
        check("rst/done", {31'd0, done1}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Main function, STEP=1 and STEP=4 latencies
        run_op("sra_pos",  2'b11, 32'h0000_0040, 5'd4,  5'd7,  32'h0000_0004, 5,  2);
        run_op("sra_neg",  2'b11, 32'h8000_0000, 5'd4,  5'd9,  32'hF800_0000, 5,  2);
        run_op("srl_neg",  2'b01, 32'h8000_0000, 5'd4,  5'd10, 32'h0800_0000, 5,  2);
        run_op("sll_31",   2'b00, 32'h0000_0001, 5'd31, 5'd1,  32'h8000_0000, 32, 9);
        run_op("sra_31",   2'b11, 32'h8000_0000, 5'd31, 5'd2,  32'hFFFF_FFFF, 32, 9);
        run_op("srl_6",    2'b01, 32'hF000_0000, 5'd6,  5'd3,  32'h03C0_0000, 7,  3);
        run_op("sll_5",    2'b00, 32'h1234_5678, 5'd5,  5'd4,  32'h468A_CF00, 6,  3);
        run_op("sra_3",    2'b11, 32'h7FFF_FFFF, 5'd3,  5'd5,  32'h0FFF_FFFF, 4,  2);
        run_op("zero_sll", 2'b00, 32'hDEAD_BEEF, 5'd0,  5'd6,  32'hDEAD_BEEF, 1,  1);
        run_op("zero_sra", 2'b11, 32'hDEAD_BEEF, 5'd0,  5'd8,  32'hDEAD_BEEF, 1,  1);
        run_op("rsvd",     2'b10, 32'hDEAD_BEEF, 5'd5,  5'd11, 32'hDEAD_BEEF, 1,  1);

        // Flush mid-shift, with an ignored start while busy
        dones = 0;
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; a_i = 32'hFFFF_0000; shamt_i = 5'd20; rd_i = 5'd13;
        @(negedge clk);
        check("busy_retry/busy", {31'd0, busy1 & busy4}, 32'd1);
        op_i = 2'b10; a_i = 32'h5555_5555; shamt_i = 5'd0; rd_i = 5'd3;
        @(negedge clk);
        dones += int'(done1) + int'(done4);
        start_i = 1'b0;
        @(negedge clk);
        dones += int'(done1) + int'(done4);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush/ready", {31'd0, ready1 & ready4}, 32'd1);
        check("flush/result_step1", result1, 32'hDEAD_BEEF);
        check("flush/result_step4", result4, 32'hDEAD_BEEF);
        check("flush/rd", {27'd0, rd1}, 32'd11);
        for (int i = 0; i < 30; i++) begin
            dones += int'(done1) + int'(done4);
            @(negedge clk);
        end
        check("flush/no_done", 32'(dones), 32'd0);

        // Flush and start together in IDLE: start dropped
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; a_i = 32'h1; shamt_i = 5'd3; rd_i = 5'd4;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        check("flush_start/ready", {31'd0, ready1 & ready4}, 32'd1);
        @(negedge clk);
        check("flush_start/no_done", {31'd0, done1 | done4 | busy1 | busy4}, 32'd0);

        // Async reset mid-shift
        start_i = 1'b1; op_i = 2'b00; a_i = 32'h1; shamt_i = 5'd20; rd_i = 5'd14;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid/busy_before", {31'd0, busy1 & busy4}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid/ready", {31'd0, ready1 & ready4}, 32'd1);
        check("rst_mid/busy", {31'd0, busy1 | busy4}, 32'd0);
        check("rst_mid/result", result1 | result4, 32'h0);
        check("rst_mid/rd", {27'd0, rd1 | rd4}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op("post_rst", 2'b01, 32'h0000_0100, 5'd8, 5'd12, 32'h0000_0001, 9, 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
